// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and the network under test / result consumer.
// Handshake: tt_valid rises when a scan completes and holds until ack (or a new start) is seen.
interface truth_table_scanner_if;
   logic         start;
   logic         x0, x1, x2, x3, x4, x5, x6;
   logic         f_in;
   logic         busy;
   logic [127:0] tt;
   logic [7:0]   ones;
   logic         tt_valid;
   logic         ack;

   modport master (
      input  start, f_in, ack,
      output x0, x1, x2, x3, x4, x5, x6, busy, tt, ones, tt_valid
   );

   modport slave (
      output start, f_in, ack,
      input  x0, x1, x2, x3, x4, x5, x6, busy, tt, ones, tt_valid
   );
endinterface

// File: rtl/truth_table_scanner.sv
// Steps a 7-input network through all 128 patterns and captures its truth table
// and ones count; results are held for the consumer until ack or a new start.
module truth_table_scanner #(
   parameter int unsigned SETTLE = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   truth_table_scanner_if.master        bus,
   output logic [1:0]                   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

   state_t         state_q, state_d;
   logic [6:0]     pattern_q, pattern_d;
   logic [3:0]     hold_q, hold_d;
   logic           finish_q, finish_d;
   logic [6:0]     x_q, x_d;
   logic           busy_q, busy_d;
   logic           tt_valid_q, tt_valid_d;
   logic [127:0]   tt_q, tt_d;
   logic [7:0]     ones_q, ones_d;

   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      hold_d     = hold_q;
      finish_d   = finish_q;
      x_d        = x_q;
      busy_d     = busy_q;
      tt_valid_d = tt_valid_q;
      tt_d       = tt_q;
      ones_d     = ones_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE && bus.ack) begin
               tt_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
            if (bus.start) begin
               state_d    = S_SCAN;
               pattern_d  = 7'd0;
               hold_d     = 4'd0;
               finish_d   = 1'b0;
               x_d        = 7'd0;
               tt_d       = '0;
               ones_d     = 8'd0;
               busy_d     = 1'b1;
               tt_valid_d = 1'b0;
            end
         end
         S_SCAN: begin
            // One extra busy cycle after the last sample before results are published.
            if (finish_q) begin
               state_d    = S_DONE;
               busy_d     = 1'b0;
               tt_valid_d = 1'b1;
               finish_d   = 1'b0;
            end else if (hold_q == HOLD_LAST) begin
               tt_d[pattern_q] = bus.f_in;
               ones_d          = ones_q + {7'd0, bus.f_in};
               hold_d          = 4'd0;
               if (pattern_q == 7'd127) begin
                  finish_d = 1'b1;
                  x_d      = 7'd0;
               end else begin
                  pattern_d = pattern_q + 7'd1;
                  x_d       = pattern_q + 7'd1;
               end
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pattern_q  <= 7'd0;
         hold_q     <= 4'd0;
         finish_q   <= 1'b0;
         x_q        <= 7'd0;
         busy_q     <= 1'b0;
         tt_valid_q <= 1'b0;
         tt_q       <= '0;
         ones_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         pattern_q  <= pattern_d;
         hold_q     <= hold_d;
         finish_q   <= finish_d;
         x_q        <= x_d;
         busy_q     <= busy_d;
         tt_valid_q <= tt_valid_d;
         tt_q       <= tt_d;
         ones_q     <= ones_d;
      end
   end

   assign bus.x0       = x_q[0];
   assign bus.x1       = x_q[1];
   assign bus.x2       = x_q[2];
   assign bus.x3       = x_q[3];
   assign bus.x4       = x_q[4];
   assign bus.x5       = x_q[5];
   assign bus.x6       = x_q[6];
   assign bus.busy     = busy_q;
   assign bus.tt_valid = tt_valid_q;
   assign bus.tt       = tt_q;
   assign bus.ones     = ones_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (SETTLE=1, 0, 3) driven by
// behavioural networks, results compared against a truth-table model.
module tb_truth_table_scanner;
   localparam int S_A = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   truth_table_scanner_if bus_a();
   truth_table_scanner_if bus_0();
   truth_table_scanner_if bus_3();
   logic [1:0] dbg_a, dbg_0, dbg_3;

   truth_table_scanner #(.SETTLE(S_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a));
   truth_table_scanner #(.SETTLE(0))   dut_0 (.clk(clk), .rst(rst), .bus(bus_0), .dbg_state(dbg_0));
   truth_table_scanner #(.SETTLE(3))   dut_3 (.clk(clk), .rst(rst), .bus(bus_3), .dbg_state(dbg_3));

   int           n_cmp = 0;
   int           n_err = 0;
   int           mode_a = 0;
   logic [127:0] rand_tt = '0;
   logic [127:0] last_et;
   int           last_eo;
   logic [6:0]   xa, xz, xt;

   // Network functions: 0 const0, 1 x0, 2 AND of all, 3 const1, 4 x6, else random table
   function automatic logic ref_f(input int mode, input logic [6:0] p);
      case (mode)
         0: return 1'b0;
         1: return p[0];
         2: return &p;
         3: return 1'b1;
         4: return p[6];
         default: return rand_tt[p];
      endcase
   endfunction

   function automatic logic [127:0] exp_tt(input int mode);
      logic [127:0] t;
      for (int i = 0; i < 128; i++) t[i] = ref_f(mode, 7'(i));
      return t;
   endfunction

   function automatic int popcnt(input logic [127:0] t);
      int c = 0;
      for (int i = 0; i < 128; i++) c += int'(t[i]);
      return c;
   endfunction

   assign xa = {bus_a.x6, bus_a.x5, bus_a.x4, bus_a.x3, bus_a.x2, bus_a.x1, bus_a.x0};
   assign xz = {bus_0.x6, bus_0.x5, bus_0.x4, bus_0.x3, bus_0.x2, bus_0.x1, bus_0.x0};
   assign xt = {bus_3.x6, bus_3.x5, bus_3.x4, bus_3.x3, bus_3.x2, bus_3.x1, bus_3.x0};
   always_comb bus_a.f_in = ref_f(mode_a, xa);
   assign bus_0.f_in = xz[6];
   assign bus_3.f_in = xt[6];

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
      n_cmp++; if (bus_a.tt_valid !== 1'b0) begin n_err++; $display("FAIL reset_tt_valid got %b want 0", bus_a.tt_valid); end
      n_cmp++; if (bus_a.tt !== 128'h0) begin n_err++; $display("FAIL reset_tt got %h want 0", bus_a.tt); end
      n_cmp++; if (bus_a.ones !== 8'd0) begin n_err++; $display("FAIL reset_ones got %0d want 0", bus_a.ones); end
      n_cmp++; if (xa !== 7'd0 || xz !== 7'd0 || xt !== 7'd0) begin n_err++; $display("FAIL reset_x got %h/%h/%h want 0", xa, xz, xt); end
      n_cmp++; if (dbg_a !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_a); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Start a scan on instance A; optionally pulse start+ack mid-scan at cycle inject_at.
   task automatic run_scan(input int mode, input int inject_at);
      logic [127:0] et;
      int eo, n, run, bad, trans;
      logic [6:0] prev;
      et = exp_tt(mode);
      eo = popcnt(et);
      last_et = et;
      last_eo = eo;
      mode_a = mode;
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      n_cmp++; if (bus_a.busy !== 1'b1 || bus_a.tt_valid !== 1'b0) begin n_err++; $display("FAIL start_flags mode %0d got busy=%b valid=%b want 1/0", mode, bus_a.busy, bus_a.tt_valid); end
      n_cmp++; if (bus_a.tt !== 128'h0 || bus_a.ones !== 8'd0) begin n_err++; $display("FAIL start_clear mode %0d got tt=%h ones=%0d want 0/0", mode, bus_a.tt, bus_a.ones); end
      n = 0; run = 1; bad = 0; trans = 0; prev = xa;
      while (bus_a.tt_valid !== 1'b1 && n < 1000) begin
         if (n == inject_at) begin bus_a.start = 1'b1; bus_a.ack = 1'b1; end
         @(posedge clk); #1;
         n++;
         bus_a.start = 1'b0;
         bus_a.ack = 1'b0;
         if (bus_a.tt_valid !== 1'b1) begin
            if (bus_a.busy !== 1'b1) bad++;
            else if (xa == prev) run++;
            else begin
               if (run != S_A + 1) bad++;
               if (xa != prev + 7'd1) bad++;
               prev = xa; run = 1; trans++;
            end
         end
      end
      n_cmp++; if (n != 128 * (S_A + 1) + 1) begin n_err++; $display("FAIL latency mode %0d got %0d want %0d", mode, n, 128 * (S_A + 1) + 1); end
      n_cmp++; if (bad != 0 || trans != 128) begin n_err++; $display("FAIL x_hold mode %0d got bad=%0d trans=%0d want 0/128", mode, bad, trans); end
      n_cmp++; if (bus_a.tt !== et) begin n_err++; $display("FAIL tt mode %0d got %h want %h", mode, bus_a.tt, et); end
      n_cmp++; if (bus_a.ones !== 8'(eo)) begin n_err++; $display("FAIL ones mode %0d got %0d want %0d", mode, bus_a.ones, eo); end
      n_cmp++; if (bus_a.busy !== 1'b0 || xa !== 7'd0 || dbg_a !== 2'd2) begin n_err++; $display("FAIL done_state mode %0d got busy=%b x=%h st=%0d want 0/0/2", mode, bus_a.busy, xa, dbg_a); end
   endtask

   task automatic test_ack();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus_a.tt_valid !== 1'b1 || bus_a.tt !== last_et) begin n_err++; $display("FAIL done_hold got valid=%b tt=%h want 1/%h", bus_a.tt_valid, bus_a.tt, last_et); end
      bus_a.ack = 1'b1;
      @(posedge clk); #1;
      bus_a.ack = 1'b0;
      n_cmp++; if (bus_a.tt_valid !== 1'b0 || dbg_a !== 2'd0) begin n_err++; $display("FAIL ack got valid=%b st=%0d want 0/0", bus_a.tt_valid, dbg_a); end
      n_cmp++; if (bus_a.tt !== last_et || bus_a.ones !== 8'(last_eo)) begin n_err++; $display("FAIL ack_keep got tt=%h ones=%0d want %h/%0d", bus_a.tt, bus_a.ones, last_et, last_eo); end
   endtask

   task automatic test_patterns();
      int modes[5] = '{0, 1, 2, 3, 5};
      foreach (modes[i]) begin
         rand_tt = {$urandom, $urandom, $urandom, $urandom};
         run_scan(modes[i], -1);
         test_ack();
      end
   endtask

   task automatic test_start_in_scan();
      rand_tt = {$urandom, $urandom, $urandom, $urandom};
      run_scan(5, $urandom_range(20, 200));
      test_ack();
   endtask

   task automatic test_start_in_done();
      run_scan(1, -1);
      run_scan(2, -1);
      test_ack();
   endtask

   task automatic test_mid_reset();
      int n;
      mode_a = 3;
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      n = 0;
      while (xa != 7'd50 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++; if (n >= 1000) begin n_err++; $display("FAIL reach_50 got x=%h want 32", xa); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (bus_a.busy !== 1'b0 || xa !== 7'd0 || dbg_a !== 2'd0) begin n_err++; $display("FAIL midrst_state got busy=%b x=%h st=%0d want 0/0/0", bus_a.busy, xa, dbg_a); end
      n_cmp++; if (bus_a.tt !== 128'h0 || bus_a.ones !== 8'd0 || bus_a.tt_valid !== 1'b0) begin n_err++; $display("FAIL midrst_clear got tt=%h ones=%0d valid=%b want 0", bus_a.tt, bus_a.ones, bus_a.tt_valid); end
      repeat (300) @(posedge clk);
      #1;
      n_cmp++; if (bus_a.tt_valid !== 1'b0 || bus_a.busy !== 1'b0) begin n_err++; $display("FAIL midrst_discard got valid=%b busy=%b want 0/0", bus_a.tt_valid, bus_a.busy); end
      rand_tt = {$urandom, $urandom, $urandom, $urandom};
      run_scan(5, -1);
      test_ack();
   endtask

   task automatic test_settle();
      logic [6:0] p0, p3;
      int r0, r3, b0, b3, t0, t3, l0, l3, n;
      logic [127:0] et;
      et = exp_tt(4);
      bus_0.start = 1'b1;
      bus_3.start = 1'b1;
      @(posedge clk); #1;
      bus_0.start = 1'b0;
      bus_3.start = 1'b0;
      p0 = xz; p3 = xt; r0 = 1; r3 = 1; b0 = 0; b3 = 0; t0 = 0; t3 = 0; l0 = -1; l3 = -1; n = 0;
      while ((l0 < 0 || l3 < 0) && n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (l0 < 0) begin
            if (bus_0.tt_valid === 1'b1) l0 = n;
            else if (xz == p0) r0++;
            else begin
               if (r0 != 1) b0++;
               if (xz != p0 + 7'd1) b0++;
               p0 = xz; r0 = 1; t0++;
            end
         end
         if (l3 < 0) begin
            if (bus_3.tt_valid === 1'b1) l3 = n;
            else if (xt == p3) r3++;
            else begin
               if (r3 != 4) b3++;
               if (xt != p3 + 7'd1) b3++;
               p3 = xt; r3 = 1; t3++;
            end
         end
      end
      n_cmp++; if (l0 != 129) begin n_err++; $display("FAIL s0_latency got %0d want 129", l0); end
      n_cmp++; if (l3 != 513) begin n_err++; $display("FAIL s3_latency got %0d want 513", l3); end
      n_cmp++; if (b0 != 0 || t0 != 128) begin n_err++; $display("FAIL s0_hold got bad=%0d trans=%0d want 0/128", b0, t0); end
      n_cmp++; if (b3 != 0 || t3 != 128) begin n_err++; $display("FAIL s3_hold got bad=%0d trans=%0d want 0/128", b3, t3); end
      n_cmp++; if (bus_0.tt !== et || bus_0.ones !== 8'd64) begin n_err++; $display("FAIL s0_result got tt=%h ones=%0d want %h/64", bus_0.tt, bus_0.ones, et); end
      n_cmp++; if (bus_3.tt !== et || bus_3.ones !== 8'd64) begin n_err++; $display("FAIL s3_result got tt=%h ones=%0d want %h/64", bus_3.tt, bus_3.ones, et); end
      n_cmp++; if (dbg_0 !== 2'd2 || dbg_3 !== 2'd2 || bus_0.busy !== 1'b0 || bus_3.busy !== 1'b0) begin n_err++; $display("FAIL settle_done got st=%0d/%0d busy=%b/%b want 2/2 0/0", dbg_0, dbg_3, bus_0.busy, bus_3.busy); end
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.ack = 1'b0;
      bus_0.start = 1'b0; bus_0.ack = 1'b0;
      bus_3.start = 1'b0; bus_3.ack = 1'b0;
      test_reset();
      test_patterns();
      test_start_in_scan();
      test_start_in_done();
      test_mid_reset();
      test_settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
